// File: rtl/gradient_kernel_pipe_pkg.sv
// gradient_pkg: shared types and helpers for the gradient kernel pipeline.
//   grad_mode_e   - per-frame kernel mode (linear Prewitt-style or sign-only)
//   acc_width     - signed accumulator width needed for a DW-bit K x K window
//   kernel_weight - weight applied to a column/row at a signed offset from centre
//   MAX_KERNEL    - largest supported window size
package gradient_pkg;

    localparam int MAX_KERNEL = 7;

    typedef enum logic {
        MODE_LINEAR = 1'b0,
        MODE_SIGN   = 1'b1
    } grad_mode_e;

    // Worst case is every off-centre tap at full scale with weight HALF,
    // which is bounded by K*K*HALF*max_pixel; one extra bit carries the sign.
    function automatic int acc_width(input int dw, input int k);
        return dw + $clog2(k * k * (k / 2)) + 1;
    endfunction

    function automatic int kernel_weight(input grad_mode_e mode, input int offset);
        if (mode == MODE_SIGN) begin
            return (offset > 0) ? 1 : ((offset < 0) ? -1 : 0);
        end
        return offset;
    endfunction

endpackage

// File: rtl/gradient_kernel_pipe_if.sv
// gradient_kernel_pipe_if: window-in / gradient-out stream bundle.
//   i_image_kernel_buffer [row][col][bit] window, row 0 = top, col 0 = left
//   i_data_valid / o_ready            upstream handshake
//   i_start_of_frame, i_mode          frame marker and kernel mode (on SOF beat)
//   o_Gx_Gy_vector {Gy,Gx}, o_data_valid / i_ready  downstream handshake
//   o_start_of_frame, o_sat_flag      frame marker and sticky saturation flag
//   o_magnitude                       only when GRAD_MAG_EN is defined
// Modports: slave = the gradient pipe, master = the surrounding environment.
interface gradient_kernel_pipe_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int LANE_WIDTH  = 16
);
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] i_image_kernel_buffer;
    logic                    i_data_valid;
    logic                    i_start_of_frame;
    logic                    i_mode;
    logic                    o_ready;
    logic [2*LANE_WIDTH-1:0] o_Gx_Gy_vector;
    logic                    o_data_valid;
    logic                    o_start_of_frame;
    logic                    i_ready;
    logic                    o_sat_flag;
`ifdef GRAD_MAG_EN
    logic [LANE_WIDTH-1:0]   o_magnitude;
`endif

    modport slave (
        input  i_image_kernel_buffer,
        input  i_data_valid,
        input  i_start_of_frame,
        input  i_mode,
        output o_ready,
        output o_Gx_Gy_vector,
        output o_data_valid,
        output o_start_of_frame,
        input  i_ready,
        output o_sat_flag
`ifdef GRAD_MAG_EN
        , output o_magnitude
`endif
    );

    modport master (
        output i_image_kernel_buffer,
        output i_data_valid,
        output i_start_of_frame,
        output i_mode,
        input  o_ready,
        input  o_Gx_Gy_vector,
        input  o_data_valid,
        input  o_start_of_frame,
        output i_ready,
        input  o_sat_flag
`ifdef GRAD_MAG_EN
        , input o_magnitude
`endif
    );

endinterface

// File: rtl/gradient_kernel_pipe_sat_pack.sv
// grad_sat_pack: output-stage register for one gradient lane.
//   clk, reset (sync, active-high), enable (pipeline advance)
//   acc  - signed accumulator value from the weighting stage
//   lane - registered lane value, clamped or sign-extended to LANE_WIDTH
//   sat  - registered: this lane was clamped
module grad_sat_pack #(
    parameter int ACC_WIDTH  = 15,
    parameter int LANE_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [LANE_WIDTH-1:0] lane,
    output logic                         sat
);

    logic signed [LANE_WIDTH-1:0] lane_d;
    logic                         sat_d;

    generate
        if (ACC_WIDTH > LANE_WIDTH) begin : g_clamp
            localparam logic signed [ACC_WIDTH-1:0] MAX_V =
                {{(ACC_WIDTH-LANE_WIDTH+1){1'b0}}, {(LANE_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] MIN_V =
                {{(ACC_WIDTH-LANE_WIDTH+1){1'b1}}, {(LANE_WIDTH-1){1'b0}}};

            // Clamp to the lane's signed range, flagging any clipping.
            always_comb begin
                lane_d = acc[LANE_WIDTH-1:0];
                sat_d  = 1'b0;
                if (acc > MAX_V) begin
                    lane_d = {1'b0, {(LANE_WIDTH-1){1'b1}}};
                    sat_d  = 1'b1;
                end else if (acc < MIN_V) begin
                    lane_d = {1'b1, {(LANE_WIDTH-1){1'b0}}};
                    sat_d  = 1'b1;
                end
            end
        end else begin : g_extend
            // The accumulator always fits, so the lane is a plain sign extension.
            always_comb begin
                lane_d = LANE_WIDTH'(acc);
                sat_d  = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            lane <= '0;
            sat  <= 1'b0;
        end else if (enable) begin
            lane <= lane_d;
            sat  <= sat_d;
        end
    end

endmodule

// File: rtl/gradient_kernel_pipe.sv
// gradient_kernel_pipe: Gx/Gy gradient engine for a KERNEL_SIZE x KERNEL_SIZE
// pixel window, one window per beat, full valid/ready backpressure.
//   i_clk, i_reset (sync, active-high)
//   bus (gradient_kernel_pipe_if.slave): window in, packed {Gy,Gx} out,
//       SOF in/out, per-frame mode, sticky saturation flag.
// Pipeline: S1 column/row sums, S2 weighted accumulate, S3 saturate/pack.
// Optional macro GRAD_MAG_EN adds an S4 stage driving o_magnitude =
// min(|Gx|+|Gy|, 2^LANE_WIDTH-1), making the latency 4 instead of 3.
module gradient_kernel_pipe
    import gradient_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int LANE_WIDTH  = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    gradient_kernel_pipe_if.slave bus
);

    localparam int HALF      = KERNEL_SIZE / 2;
    localparam int SUM_WIDTH = DATA_WIDTH + $clog2(KERNEL_SIZE);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, KERNEL_SIZE);

    // One global advance: every stage moves together or holds together.
    logic adv;
    logic out_valid;
    assign adv         = ~out_valid | bus.i_ready;
    assign bus.o_ready = adv;

    // The SOF beat uses its own i_mode directly; later beats use the stored one.
    logic       sof_beat;
    grad_mode_e mode_reg;
    grad_mode_e beat_mode;
    assign sof_beat  = bus.i_data_valid & bus.i_start_of_frame;
    assign beat_mode = sof_beat ? grad_mode_e'(bus.i_mode) : mode_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_reg <= MODE_LINEAR;
        end else if (adv && sof_beat) begin
            mode_reg <= grad_mode_e'(bus.i_mode);
        end
    end

    // S1: unsigned column sums feed Gx, row sums feed Gy.
    logic [KERNEL_SIZE-1:0][SUM_WIDTH-1:0] col_sum_d, row_sum_d;
    always_comb begin
        col_sum_d = '0;
        row_sum_d = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                col_sum_d[c] = col_sum_d[c] + SUM_WIDTH'(bus.i_image_kernel_buffer[r][c]);
                row_sum_d[r] = row_sum_d[r] + SUM_WIDTH'(bus.i_image_kernel_buffer[r][c]);
            end
        end
    end

    logic                                  s1_valid, s1_sof;
    grad_mode_e                            s1_mode;
    logic [KERNEL_SIZE-1:0][SUM_WIDTH-1:0] s1_col_sum, s1_row_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_mode    <= MODE_LINEAR;
            s1_col_sum <= '0;
            s1_row_sum <= '0;
        end else if (adv) begin
            s1_valid   <= bus.i_data_valid;
            s1_sof     <= sof_beat;
            s1_mode    <= beat_mode;
            s1_col_sum <= col_sum_d;
            s1_row_sum <= row_sum_d;
        end
    end

    // S2: weighted accumulate. Left columns and bottom rows carry negative
    // weights; the centre tap has weight 0 and is skipped entirely.
    logic signed [ACC_WIDTH-1:0] gx_d, gy_d;
    always_comb begin
        gx_d = '0;
        gy_d = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (i != HALF) begin
                gx_d = gx_d + $signed(ACC_WIDTH'(kernel_weight(s1_mode, i - HALF)))
                            * $signed(ACC_WIDTH'(s1_col_sum[i]));
                gy_d = gy_d + $signed(ACC_WIDTH'(kernel_weight(s1_mode, HALF - i)))
                            * $signed(ACC_WIDTH'(s1_row_sum[i]));
            end
        end
    end

    logic                        s2_valid, s2_sof;
    logic signed [ACC_WIDTH-1:0] s2_gx, s2_gy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_gx    <= '0;
            s2_gy    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_gx    <= gx_d;
            s2_gy    <= gy_d;
        end
    end

    // S3: per-lane saturation and packing.
    logic                         s3_valid, s3_sof;
    logic signed [LANE_WIDTH-1:0] s3_gx, s3_gy;
    logic                         s3_sat_x, s3_sat_y;

    grad_sat_pack #(.ACC_WIDTH(ACC_WIDTH), .LANE_WIDTH(LANE_WIDTH)) u_sat_x (
        .clk(i_clk), .reset(i_reset), .enable(adv),
        .acc(s2_gx), .lane(s3_gx), .sat(s3_sat_x)
    );

    grad_sat_pack #(.ACC_WIDTH(ACC_WIDTH), .LANE_WIDTH(LANE_WIDTH)) u_sat_y (
        .clk(i_clk), .reset(i_reset), .enable(adv),
        .acc(s2_gy), .lane(s3_gy), .sat(s3_sat_y)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s3_valid <= 1'b0;
            s3_sof   <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            s3_sof   <= s2_sof;
        end
    end

    logic                         out_sof, out_sat;
    logic signed [LANE_WIDTH-1:0] out_gx, out_gy;

`ifdef GRAD_MAG_EN
    // S4: L1 magnitude of the saturated lanes. |-2^(LANE-1)| needs one
    // extra bit, and the sum one more before clamping back to LANE bits.
    logic signed [LANE_WIDTH:0]   ext_x, ext_y;
    logic        [LANE_WIDTH:0]   abs_x, abs_y;
    logic        [LANE_WIDTH+1:0] mag_sum;
    logic        [LANE_WIDTH-1:0] mag_d;
    always_comb begin
        ext_x   = {s3_gx[LANE_WIDTH-1], s3_gx};
        ext_y   = {s3_gy[LANE_WIDTH-1], s3_gy};
        abs_x   = ext_x[LANE_WIDTH] ? $unsigned(-ext_x) : $unsigned(ext_x);
        abs_y   = ext_y[LANE_WIDTH] ? $unsigned(-ext_y) : $unsigned(ext_y);
        mag_sum = {1'b0, abs_x} + {1'b0, abs_y};
        mag_d   = (mag_sum > {2'b00, {LANE_WIDTH{1'b1}}}) ? '1 : mag_sum[LANE_WIDTH-1:0];
    end

    logic                  s4_valid, s4_sof, s4_sat;
    logic [LANE_WIDTH-1:0] s4_gx, s4_gy, s4_mag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s4_valid <= 1'b0;
            s4_sof   <= 1'b0;
            s4_sat   <= 1'b0;
            s4_gx    <= '0;
            s4_gy    <= '0;
            s4_mag   <= '0;
        end else if (adv) begin
            s4_valid <= s3_valid;
            s4_sof   <= s3_sof;
            s4_sat   <= s3_sat_x | s3_sat_y;
            s4_gx    <= s3_gx;
            s4_gy    <= s3_gy;
            s4_mag   <= mag_d;
        end
    end

    assign out_valid       = s4_valid;
    assign out_sof         = s4_sof;
    assign out_sat         = s4_sat;
    assign out_gx          = s4_gx;
    assign out_gy          = s4_gy;
    assign bus.o_magnitude = s4_mag;
`else
    assign out_valid = s3_valid;
    assign out_sof   = s3_sof;
    assign out_sat   = s3_sat_x | s3_sat_y;
    assign out_gx    = s3_gx;
    assign out_gy    = s3_gy;
`endif

    // Sticky flag: sat_hist holds the frame's history up to the previous
    // consumed word; the word on the output folds in (or restarts it on SOF)
    // as soon as it appears, and the result is committed when it is consumed.
    logic sat_hist, frame_sat;
    always_comb begin
        frame_sat = sat_hist;
        if (out_valid) begin
            frame_sat = (out_sof ? 1'b0 : sat_hist) | out_sat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sat_hist <= 1'b0;
        end else if (out_valid && bus.i_ready) begin
            sat_hist <= frame_sat;
        end
    end

    assign bus.o_Gx_Gy_vector   = {out_gy, out_gx};
    assign bus.o_data_valid     = out_valid;
    assign bus.o_start_of_frame = out_sof;
    assign bus.o_sat_flag       = frame_sat;

endmodule

// File: tb/tb_gradient_kernel_pipe.sv
// tb_gradient_kernel_pipe: self-checking bench for gradient_kernel_pipe.
// Instance A (8-bit, 5x5) covers directed vectors, backpressure, reset and a
// randomised stream against a scoreboard; instance B (10-bit, 7x7) covers
// lane saturation and the sticky flag.
module tb_gradient_kernel_pipe;

`ifdef GRAD_MAG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef int win_t [7][7];

    typedef struct {
        logic [31:0] vec;
        bit          sof;
        bit          flag;
        int          mag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gradient_kernel_pipe_if #(.DATA_WIDTH(8),  .KERNEL_SIZE(5), .LANE_WIDTH(16)) ifa ();
    gradient_kernel_pipe_if #(.DATA_WIDTH(10), .KERNEL_SIZE(7), .LANE_WIDTH(16)) ifb ();

    gradient_kernel_pipe #(.DATA_WIDTH(8),  .KERNEL_SIZE(5), .LANE_WIDTH(16)) dut_a (
        .i_clk(clk), .i_reset(rst), .bus(ifa.slave)
    );
    gradient_kernel_pipe #(.DATA_WIDTH(10), .KERNEL_SIZE(7), .LANE_WIDTH(16)) dut_b (
        .i_clk(clk), .i_reset(rst), .bus(ifb.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];
    bit   m_mode   = 1'b0;
    bit   m_flag   = 1'b0;

    logic        last_valid, last_ready, last_accept, last_flag;
    logic [31:0] last_vec;
    logic        lastb_valid, lastb_flag;
    logic [31:0] lastb_vec;

    // ---------------- reference model ----------------
    function automatic int wgt(bit mode, int off);
        if (!mode) return off;
        return (off > 0) ? 1 : ((off < 0) ? -1 : 0);
    endfunction

    function automatic int gradX(win_t p, int k, bit mode);
        int s = 0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                s += wgt(mode, c - k / 2) * p[r][c];
        return s;
    endfunction

    function automatic int gradY(win_t p, int k, bit mode);
        int s = 0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                s += wgt(mode, k / 2 - r) * p[r][c];
        return s;
    endfunction

    function automatic int clampLane(int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int absI(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic pushModel(win_t p, bit sof, bit mode_in);
        exp_t e;
        int gx, gy, cx, cy, m;
        bit sat;
        if (sof) m_mode = mode_in;
        gx  = gradX(p, 5, m_mode);
        gy  = gradY(p, 5, m_mode);
        cx  = clampLane(gx);
        cy  = clampLane(gy);
        sat = (cx != gx) || (cy != gy);
        m_flag = sof ? sat : (m_flag | sat);
        m = absI(cx) + absI(cy);
        e.vec  = {16'(cy), 16'(cx)};
        e.sof  = sof;
        e.flag = m_flag;
        e.mag  = (m > 65535) ? 65535 : m;
        sbq.push_back(e);
    endtask

    // ---------------- window builders ----------------
    function automatic win_t uniform(int v);
        win_t p;
        for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) p[r][c] = v;
        return p;
    endfunction

    function automatic win_t colRamp(int step);
        win_t p;
        for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) p[r][c] = step * c;
        return p;
    endfunction

    function automatic win_t colSplit(int k, int left, int mid, int right);
        win_t p;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                p[r][c] = (c < k / 2) ? left : ((c == k / 2) ? mid : right);
        return p;
    endfunction

    function automatic win_t transpose(win_t p);
        win_t q;
        for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) q[r][c] = p[c][r];
        return q;
    endfunction

    function automatic win_t randWin();
        win_t p;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                case ($urandom_range(0, 7))
                    0:       p[r][c] = 0;
                    1:       p[r][c] = 255;
                    default: p[r][c] = int'($urandom_range(0, 255));
                endcase
        return p;
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One cycle on instance A: drive, sample before the edge, score.
    task automatic applyStimulus(win_t p, bit vld, bit sof, bit mode, bit rdy);
        exp_t e;
        @(negedge clk);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                ifa.i_image_kernel_buffer[r][c] = 8'(p[r][c]);
        ifa.i_data_valid     = vld;
        ifa.i_start_of_frame = sof;
        ifa.i_mode           = mode;
        ifa.i_ready          = rdy;
        #1;
        last_valid  = ifa.o_data_valid;
        last_ready  = ifa.o_ready;
        last_vec    = ifa.o_Gx_Gy_vector;
        last_flag   = ifa.o_sat_flag;
        last_accept = vld && ifa.o_ready;
        if (ifa.o_data_valid && rdy) begin
            if (sbq.size() == 0) begin
                checkOutput("word_expected", 64'(ifa.o_data_valid), 64'(sbq.size() > 0));
            end else begin
                e = sbq.pop_front();
                checkOutput("vector",   ifa.o_Gx_Gy_vector,   e.vec);
                checkOutput("sof",      ifa.o_start_of_frame, e.sof);
                checkOutput("sat_flag", ifa.o_sat_flag,       e.flag);
`ifdef GRAD_MAG_EN
                checkOutput("magnitude", ifa.o_magnitude, e.mag);
`endif
            end
        end
        if (last_accept) pushModel(p, sof, mode);
        @(posedge clk);
    endtask

    // Single beat on A followed by idle cycles; checks the first word seen.
    task automatic runSingle(string tag, win_t p, bit sof, bit mode,
                             logic [31:0] want, bit want_flag);
        bit seen = 0;
        int lat  = -1;
        logic [31:0] got = 32'hDEAD_BEEF;
        logic gflag = 1'bx;
        applyStimulus(p, 1, sof, mode, 1);
        for (int n = 1; n <= LAT + 2; n++) begin
            applyStimulus(uniform(0), 0, 0, 0, 1);
            if (last_valid && !seen) begin
                seen = 1; lat = n; got = last_vec; gflag = last_flag;
            end
        end
        checkOutput({tag, "_vector"},  got,   want);
        checkOutput({tag, "_latency"}, lat,   LAT);
        checkOutput({tag, "_flag"},    gflag, want_flag);
    endtask

    task automatic applyB(win_t p, bit vld, bit sof);
        @(negedge clk);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                ifb.i_image_kernel_buffer[r][c] = 10'(p[r][c]);
        ifb.i_data_valid     = vld;
        ifb.i_start_of_frame = sof;
        ifb.i_mode           = 1'b0;
        ifb.i_ready          = 1'b1;
        #1;
        lastb_valid = ifb.o_data_valid;
        lastb_vec   = ifb.o_Gx_Gy_vector;
        lastb_flag  = ifb.o_sat_flag;
        @(posedge clk);
    endtask

    task automatic runB(string tag, win_t p, bit sof, logic [31:0] want, bit want_flag);
        bit seen = 0;
        logic [31:0] got = 32'hDEAD_BEEF;
        logic gflag = 1'bx;
        applyB(p, 1, sof);
        for (int n = 1; n <= LAT + 2; n++) begin
            applyB(uniform(0), 0, 0);
            if (lastb_valid && !seen) begin
                seen = 1; got = lastb_vec; gflag = lastb_flag;
            end
        end
        checkOutput({tag, "_vector"}, got,   want);
        checkOutput({tag, "_flag"},   gflag, want_flag);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        ifa.i_data_valid = 1'b1;
        ifa.i_ready      = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_valid",  ifa.o_data_valid,   0);
        checkOutput("reset_flag",   ifa.o_sat_flag,     0);
        checkOutput("reset_vector", ifa.o_Gx_Gy_vector, 0);
        @(negedge clk);
        rst = 1'b0;
        ifa.i_data_valid = 1'b0;
        #1;
        checkOutput("reset_ready", ifa.o_ready, 1);
        sbq.delete();
        m_mode = 1'b0;
        m_flag = 1'b0;
    endtask

    task automatic drain(string tag);
        for (int n = 0; n < LAT + 3; n++) applyStimulus(uniform(0), 0, 0, 0, 1);
        checkOutput({tag, "_pending"}, sbq.size(), 0);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        win_t beats[8];
        win_t cur;
        int   idx, cyc;
        bit   rdy, vld, sof, mode;

        ifa.i_image_kernel_buffer = '0;
        ifa.i_data_valid = 0; ifa.i_start_of_frame = 0; ifa.i_mode = 0; ifa.i_ready = 1;
        ifb.i_image_kernel_buffer = '0;
        ifb.i_data_valid = 0; ifb.i_start_of_frame = 0; ifb.i_mode = 0; ifb.i_ready = 1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_valid",  ifa.o_data_valid,   0);
        checkOutput("init_vector", ifa.o_Gx_Gy_vector, 0);
        checkOutput("init_flag",   ifa.o_sat_flag,     0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("init_ready", ifa.o_ready, 1);
        $display("[TB] reset released");

        // Ramp window in both modes; mode follows SOF only.
        runSingle("t1_linear",     colRamp(10), 1, 0, 32'h0000_01F4, 0);
        runSingle("t2_sign",       colRamp(10), 1, 1, 32'h0000_012C, 0);
        runSingle("t2_nosof_mode", colRamp(10), 0, 0, 32'h0000_012C, 0);
        runSingle("t2_relinear",   colRamp(10), 1, 0, 32'h0000_01F4, 0);

        // Step edges and flat field.
        runSingle("t3_step_x", colSplit(5, 0, 128, 255), 1, 0, 32'h0000_0EF1, 0);
        runSingle("t3_step_y", transpose(colSplit(5, 0, 128, 255)), 0, 0, 32'hF10F_0000, 0);
        runSingle("t4_flat",   uniform(255), 1, 0, 32'h0000_0000, 0);

        // Saturation on the 10-bit 7x7 instance.
        $display("[TB] saturation sequence");
        runB("t5_pos_sat", colSplit(7, 0, 500, 1023), 1, 32'h0000_7FFF, 1);
        runB("t5_sticky",  uniform(0), 0, 32'h0000_0000, 1);
        runB("t5_clear",   uniform(300), 1, 32'h0000_0000, 0);
        runB("t5_neg_sat", colSplit(7, 1023, 500, 0), 1, 32'h0000_8000, 1);
        runB("t5_gy_sat",  transpose(colSplit(7, 0, 500, 1023)), 1, 32'h8000_0000, 1);

        // Backpressure: 8 beats, downstream stalls 4 cycles mid-stream.
        $display("[TB] backpressure sequence");
        for (int i = 0; i < 8; i++) beats[i] = randWin();
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            rdy = !(cyc >= 5 && cyc < 9);
            applyStimulus(beats[idx], 1, idx == 0, 1'(idx == 0), rdy);
            if (!rdy) begin
                checkOutput("stall_ready", last_ready, 0);
                checkOutput("stall_valid", last_valid, 1);
            end
            if (last_accept) idx++;
            cyc++;
        end
        checkOutput("stream_count", idx, 8);
        drain("t6_stream");

        // Reset mid-stream: in-flight beats vanish, mode returns to linear.
        runSingle("t6_pre_reset_sign", colRamp(10), 1, 1, 32'h0000_012C, 0);
        for (int i = 0; i < 3; i++) applyStimulus(randWin(), 1, 0, 0, 1);
        pulseReset();
        for (int n = 0; n < LAT + 2; n++) applyStimulus(uniform(0), 0, 0, 0, 1);
        checkOutput("post_reset_quiet", last_valid, 0);
        runSingle("t6_post_reset_mode", colRamp(10), 0, 1, 32'h0000_01F4, 0);

        // Randomised stream with random gaps, stalls, frames and modes.
        $display("[TB] random stream");
        for (int n = 0; n < 400; n++) begin
            cur  = randWin();
            vld  = ($urandom_range(0, 9) < 7);
            sof  = ($urandom_range(0, 7) == 0);
            mode = 1'($urandom_range(0, 1));
            rdy  = ($urandom_range(0, 3) != 0);
            applyStimulus(cur, vld, sof, mode, rdy);
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
